// File: rtl/rr_arbiter_16.sv
// rr_arbiter_16: 16-way round-robin arbiter with a bounded tenure under contention.
// Grant index and valid are registered. The one-hot grant and the contention flag are derived combinationally.
module rr_arbiter_16 #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] req,
   output logic        gnt_valid,
   output logic [3:0]  gnt_idx,
   output logic [15:0] gnt,
   output logic        busy_others
);

   typedef enum logic {IDLE, GRANT} state_t;

   // With MAX_HOLD=0 the tenure counter only needs to stop at its ceiling so it never wraps.
   localparam logic [7:0] HOLD_SAT   = (MAX_HOLD == 0) ? 8'd255 : 8'(MAX_HOLD);
   localparam logic       PREEMPT_EN = (MAX_HOLD != 0);

   state_t      state_q, state_d;
   logic        gnt_valid_q, gnt_valid_d;
   logic [3:0]  gnt_idx_q, gnt_idx_d;
   logic [3:0]  ptr_q, ptr_d;
   logic [7:0]  hold_cnt_q, hold_cnt_d;
   logic [15:0] own_bit;
   logic [15:0] others;
   logic [3:0]  pick_idle;
   logic [3:0]  pick_other;

   function automatic logic [3:0] pick(input logic [15:0] mask, input logic [3:0] start);
      logic [3:0] idx;
      logic       found;
      pick  = start;
      found = 1'b0;
      for (int i = 0; i < 16; i++) begin
         idx = start + 4'(i);
         if (!found && mask[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   endfunction

   always_comb begin
      own_bit     = 16'h0001 << gnt_idx_q;
      others      = req & ~own_bit;
      pick_idle   = pick(req, ptr_q);
      pick_other  = pick(others, gnt_idx_q + 4'd1);
      state_d     = state_q;
      gnt_valid_d = gnt_valid_q;
      gnt_idx_d   = gnt_idx_q;
      ptr_d       = ptr_q;
      hold_cnt_d  = hold_cnt_q;
      case (state_q)
         IDLE: begin
            if (req != 16'h0000) begin
               state_d     = GRANT;
               gnt_valid_d = 1'b1;
               gnt_idx_d   = pick_idle;
               hold_cnt_d  = 8'd1;
               ptr_d       = pick_idle + 4'd1;
            end
         end
         GRANT: begin
            if (!req[gnt_idx_q]) begin
               // Hand over directly on release so the resource never sees a dead cycle.
               if (others != 16'h0000) begin
                  gnt_idx_d  = pick_other;
                  hold_cnt_d = 8'd1;
                  ptr_d      = pick_other + 4'd1;
               end else begin
                  state_d     = IDLE;
                  gnt_valid_d = 1'b0;
               end
            end else if (PREEMPT_EN && hold_cnt_q == HOLD_SAT && others != 16'h0000) begin
               gnt_idx_d  = pick_other;
               hold_cnt_d = 8'd1;
               ptr_d      = pick_other + 4'd1;
            end else if (hold_cnt_q != HOLD_SAT) begin
               hold_cnt_d = hold_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d     = IDLE;
            gnt_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         gnt_valid_q <= 1'b0;
         gnt_idx_q   <= 4'd0;
         ptr_q       <= 4'd0;
         hold_cnt_q  <= 8'd0;
      end else begin
         state_q     <= state_d;
         gnt_valid_q <= gnt_valid_d;
         gnt_idx_q   <= gnt_idx_d;
         ptr_q       <= ptr_d;
         hold_cnt_q  <= hold_cnt_d;
      end
   end

   assign gnt_valid   = gnt_valid_q;
   assign gnt_idx     = gnt_idx_q;
   assign gnt         = gnt_valid_q ? own_bit : 16'h0000;
   assign busy_others = gnt_valid_q && (others != 16'h0000);

endmodule
